// File: rtl/traffic_pkg.sv
// Shared lamp encodings, direction codes and FSM states for the intersection phase controller.
package traffic_pkg;

   localparam logic [1:0] LT_RED = 2'b00;
   localparam logic [1:0] LT_YEL = 2'b01;
   localparam logic [1:0] LT_GRN = 2'b10;

   localparam logic DIR_NS = 1'b1;
   localparam logic DIR_EW = 1'b0;

   typedef enum logic [1:0] {
      ALLRED = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } state_t;

   // Green length in ticks: base plus a quarter of the score, clamped to the ceiling.
   function automatic logic [7:0] green_len(input logic [6:0] score,
                                            input logic [7:0] min_g,
                                            input logic [7:0] max_g);
      logic [7:0] sum;
      sum = min_g + {3'b000, score[6:2]};
      return (sum > max_g) ? max_g : sum;
   endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler producing one tick every TICK_DIV cycles; restart realigns it to zero.
module tick_gen #(
   parameter int TICK_DIV = 1000
) (
   input  logic clk,
   input  logic restart,
   output logic tick
);

   localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(TICK_DIV - 1));

   always_ff @(posedge clk) begin
      if (restart || tick) cnt <= '0;
      else                 cnt <= cnt + CW'(1);
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Intersection phase sequencer: green -> yellow -> all-red, with score-scaled greens and a hold limit.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int TICK_DIV  = 1000,
   parameter int MIN_GREEN = 5,
   parameter int MAX_GREEN = 30,
   parameter int YELLOW_T  = 3,
   parameter int ALLRED_T  = 1,
   parameter int MAX_HOLD  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] score_in,
   input  logic       dir_in,
   input  logic       score_valid,
   output logic       score_ready,
   output logic [1:0] ns_light,
   output logic [1:0] ew_light,
   output logic       cur_dir,
   output logic       phase_start
);

   state_t     state;
   logic [7:0] timer;
   logic [3:0] hold;
   logic       fresh;
   logic [6:0] lat_score;
   logic       lat_dir;

   logic       tick;
   logic       phase_done;
   logic       decide;
   logic       xfer;
   logic       eff_fresh;
   logic [6:0] eff_score;
   logic       eff_dir;
   logic       req_dir;
   logic       new_dir;
   logic [7:0] g_len;
   logic [1:0] lamp;

   assign score_ready = !rst;
   assign xfer        = score_valid && !rst;
   assign phase_done  = tick && (timer == 8'd1);
   assign decide      = phase_done && (state == ALLRED);

   // Restarting on every phase exit keeps each phase an exact multiple of TICK_DIV.
   tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .restart (rst || phase_done),
      .tick    (tick)
   );

   // A transfer landing in the decision cycle takes precedence over the latch.
   always_comb begin
      eff_fresh = xfer || fresh;
      eff_score = xfer ? score_in : lat_score;
      eff_dir   = xfer ? dir_in : lat_dir;
      req_dir   = eff_fresh ? eff_dir : !cur_dir;
      g_len     = eff_fresh ? green_len(eff_score, 8'(MIN_GREEN), 8'(MAX_GREEN))
                            : 8'(MIN_GREEN);
      new_dir   = ((req_dir == cur_dir) && (hold == 4'(MAX_HOLD))) ? !cur_dir : req_dir;
   end

   always_comb begin
      lamp = LT_RED;
      case (state)
         GREEN:   lamp = LT_GRN;
         YELLOW:  lamp = LT_YEL;
         default: lamp = LT_RED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ALLRED;
         timer       <= 8'(ALLRED_T);
         hold        <= '0;
         fresh       <= 1'b0;
         cur_dir     <= DIR_EW;
         phase_start <= 1'b0;
         ns_light    <= LT_RED;
         ew_light    <= LT_RED;
      end else begin
         ns_light    <= (cur_dir == DIR_NS) ? lamp : LT_RED;
         ew_light    <= (cur_dir == DIR_EW) ? lamp : LT_RED;
         phase_start <= decide;

         if (phase_done) begin
            case (state)
               ALLRED: begin
                  state   <= GREEN;
                  timer   <= g_len;
                  cur_dir <= new_dir;
                  if (new_dir != cur_dir)         hold <= 4'd1;
                  else if (hold != 4'(MAX_HOLD))  hold <= hold + 4'd1;
               end
               GREEN: begin
                  state <= YELLOW;
                  timer <= 8'(YELLOW_T);
               end
               default: begin
                  state <= ALLRED;
                  timer <= 8'(ALLRED_T);
               end
            endcase
         end else if (tick) begin
            timer <= timer - 8'd1;
         end

         if (decide)    fresh <= 1'b0;
         else if (xfer) fresh <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (xfer) begin
         lat_score <= score_in;
         lat_dir   <= dir_in;
      end
   end

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: cycle-count phase model, directed phase checks and randomized traffic.
module tb_traffic_phase_ctrl;

   localparam int TD    = 4;
   localparam int MING  = 5;
   localparam int MAXG  = 30;
   localparam int YELT  = 3;
   localparam int ARED  = 1;
   localparam int MHOLD = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] score_in = '0;
   logic       dir_in = 1'b0;
   logic       score_valid = 1'b0;
   logic       score_ready;
   logic [1:0] ns_light;
   logic [1:0] ew_light;
   logic       cur_dir;
   logic       phase_start;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit rnd_mode = 0;

   typedef struct {
      int         at;
      logic [6:0] s;
      logic       d;
   } xfer_t;
   xfer_t sq[$];

   traffic_phase_ctrl #(
      .TICK_DIV(TD), .MIN_GREEN(MING), .MAX_GREEN(MAXG),
      .YELLOW_T(YELT), .ALLRED_T(ARED), .MAX_HOLD(MHOLD)
   ) dut (
      .clk(clk), .rst(rst), .score_in(score_in), .dir_in(dir_in),
      .score_valid(score_valid), .score_ready(score_ready),
      .ns_light(ns_light), .ew_light(ew_light),
      .cur_dir(cur_dir), .phase_start(phase_start)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Input driver: scheduled transfers in directed mode, random traffic otherwise.
   always @(negedge clk) begin
      score_valid = 1'b0;
      score_in    = 7'($urandom_range(0, 127));
      dir_in      = 1'($urandom_range(0, 1));
      if (rnd_mode) begin
         if ($urandom_range(0, 7) == 0) score_valid = 1'b1;
      end else if (sq.size() > 0 && sq[0].at == cyc) begin
         score_valid = 1'b1;
         score_in    = sq[0].s;
         dir_in      = sq[0].d;
         void'(sq.pop_front());
      end
   end

   // Reference model: each phase is simply a count of remaining clock cycles.
   localparam int PH_AR = 0, PH_GR = 1, PH_YE = 2;
   int m_ph, m_left, m_hold, m_score, m_ns, m_ew, m_g;
   bit m_dir, m_fresh, m_ldir, m_start, m_ok = 0;

   always @(posedge clk) begin
      bit dec, f, d, req;
      int s, code;
      if (rst) begin
         m_ph = PH_AR; m_left = ARED * TD; m_dir = 0; m_hold = 0;
         m_fresh = 0; m_start = 0; m_ns = 0; m_ew = 0; m_ok = 1;
      end else if (m_ok) begin
         code = (m_ph == PH_GR) ? 2 : (m_ph == PH_YE) ? 1 : 0;
         m_ns = m_dir ? code : 0;
         m_ew = m_dir ? 0 : code;
         m_start = 0;
         dec = 0;
         if (m_left == 1) begin
            if (m_ph == PH_AR) begin
               dec = 1;
               f = score_valid || m_fresh;
               s = score_valid ? int'(score_in) : m_score;
               d = score_valid ? dir_in : m_ldir;
               if (f) begin
                  req = d;
                  m_g = MING + s / 4;
                  if (m_g > MAXG) m_g = MAXG;
               end else begin
                  req = !m_dir;
                  m_g = MING;
               end
               if (req == m_dir && m_hold == MHOLD) req = !m_dir;
               if (req == m_dir) m_hold = (m_hold < MHOLD) ? m_hold + 1 : MHOLD;
               else              m_hold = 1;
               m_dir = req; m_ph = PH_GR; m_left = m_g * TD; m_start = 1; m_fresh = 0;
            end else if (m_ph == PH_GR) begin
               m_ph = PH_YE; m_left = YELT * TD;
            end else begin
               m_ph = PH_AR; m_left = ARED * TD;
            end
         end else begin
            m_left--;
         end
         if (score_valid && !dec) begin
            m_fresh = 1; m_score = int'(score_in); m_ldir = dir_in;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (m_ok) begin
         check("ns_light", int'(ns_light), m_ns);
         check("ew_light", int'(ew_light), m_ew);
         check("cur_dir", int'(cur_dir), int'(m_dir));
         check("phase_start", int'(phase_start), int'(m_start));
         check("score_ready", int'(score_ready), int'(!rst));
      end
   end

   task automatic sched(input int at, input int s, input bit d);
      xfer_t x;
      x.at = at; x.s = 7'(s); x.d = d;
      sq.push_back(x);
   endtask

   task automatic wait_start(output int n);
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         n++;
         if (phase_start) break;
      end
   endtask

   // Called right after a phase_start: counts lamp states up to the next phase_start.
   task automatic run_phase(input string tag, input bit d, input int eg);
      int g, y, r;
      bit done;
      logic [1:0] lamp;
      g = 0; y = 0; r = 0; done = 0;
      check({tag, "_dir"}, int'(cur_dir), int'(d));
      for (int i = 0; i < 300 && !done; i++) begin
         @(posedge clk); #1;
         lamp = d ? ns_light : ew_light;
         if (lamp == 2'b10)      g++;
         else if (lamp == 2'b01) y++;
         else                    r++;
         if (phase_start) done = 1;
      end
      check({tag, "_timeout"}, int'(!done), 0);
      check({tag, "_green"}, g, eg);
      check({tag, "_yellow"}, y, YELT * TD);
      check({tag, "_allred"}, r, ARED * TD);
   endtask

   initial begin
      int n;
      repeat (3) @(posedge clk);
      #1;
      check("rst_lamps", int'({ns_light, ew_light}), 0);
      check("rst_ready", int'(score_ready), 0);
      @(negedge clk) rst = 1'b0;
      wait_start(n);
      check("first_start_lat", n, 4);

      run_phase("p1", 1, 20);
      run_phase("p2", 0, 20);
      sched(cyc + 5 * TD + 13, 40, 1);
      run_phase("p3", 1, 20);
      sched(cyc + 15 * TD + 13, 100, 0);
      run_phase("p4_s40", 1, 60);
      sched(cyc + 30 * TD + 13, 127, 0);
      run_phase("p5_s100", 0, 120);
      run_phase("p6_s127", 0, 120);
      sched(cyc + 5 * TD + 13, 20, 1);
      run_phase("p7_alt", 1, 20);
      sched(cyc + 10 * TD + 13, 20, 1);
      run_phase("p8_hold", 1, 40);
      sched(cyc + 10 * TD + 13, 20, 1);
      run_phase("p9_forced", 0, 40);
      sched(cyc + 2, 8, 0);
      sched(cyc + 10 * TD + 15, 60, 1);
      run_phase("p10", 1, 40);
      run_phase("p11_overwrite", 1, 80);

      repeat (30) @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("midrst_lamps", int'({ns_light, ew_light}), 0);
      check("midrst_ready", int'(score_ready), 0);
      check("midrst_start", int'(phase_start), 0);
      @(negedge clk) rst = 1'b0;
      wait_start(n);
      check("midrst_start_lat", n, 4);
      run_phase("p12", 1, 20);

      rnd_mode = 1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (rst) rst = ($urandom_range(0, 2) != 0);
         else     rst = ($urandom_range(0, 799) == 0);
      end
      @(negedge clk) rst = 1'b0;
      rnd_mode = 0;
      repeat (5) @(posedge clk);
      #2;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
